// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline control logic:
// memory wait-state FSM encoding and register-index width.
package arm_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard compare between the decode stage and the EXE/MEM stages.
// With forwarding only a load in EXE can still conflict; without it any pending write does.
module hazard_detect
  import arm_pkg::*;
(
  input  logic                 forwardEnable,
  input  logic [REG_IDX_W-1:0] src1_id,
  input  logic [REG_IDX_W-1:0] src2_id,
  input  logic                 src1Used_id,
  input  logic                 twoSrc_id,
  input  logic [REG_IDX_W-1:0] destination_exe,
  input  logic                 writebackEnabled_exe,
  input  logic                 memoryReadEnabled_exe,
  input  logic [REG_IDX_W-1:0] destination_mem,
  input  logic                 writebackEnabled_mem,
  output logic                 hazard_id
);

  logic src1_exe, src2_exe, src1_mem, src2_mem;
  logic exe_match, mem_match;

  assign src1_exe = src1Used_id && (src1_id == destination_exe);
  assign src2_exe = twoSrc_id   && (src2_id == destination_exe);
  assign src1_mem = src1Used_id && (src1_id == destination_mem);
  assign src2_mem = twoSrc_id   && (src2_id == destination_mem);

  assign exe_match = src1_exe || src2_exe;
  assign mem_match = src1_mem || src2_mem;

  assign hazard_id = forwardEnable
                   ? (exe_match && memoryReadEnabled_exe)
                   : ((exe_match && writebackEnabled_exe) || (mem_match && writebackEnabled_mem));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory wait-state FSM, stall/flush priority (memory, branch, hazard)
// and saturating stall counters for performance debug.
module pipeline_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 forwardEnable,
  input  logic [REG_IDX_W-1:0] src1_id,
  input  logic [REG_IDX_W-1:0] src2_id,
  input  logic                 src1Used_id,
  input  logic                 twoSrc_id,
  input  logic [REG_IDX_W-1:0] destination_exe,
  input  logic                 writebackEnabled_exe,
  input  logic                 memoryReadEnabled_exe,
  input  logic [REG_IDX_W-1:0] destination_mem,
  input  logic                 writebackEnabled_mem,
  input  logic                 memoryReadEnabled_mem,
  input  logic                 memoryWriteEnabled_mem,
  input  logic                 branchTaken_exe,
  output logic                 hazard_id,
  output logic                 freeze_if,
  output logic                 freeze_id,
  output logic                 freeze_exe,
  output logic                 freeze_mem,
  output logic                 freeze_wb,
  output logic                 flush_id,
  output logic                 flush_exe,
  output logic                 memBusy,
  output logic [CNT_W-1:0]     hazardStallCount,
  output logic [CNT_W-1:0]     memStallCount
);

  // The IDLE cycle counts as the first stall, MEM_DONE is not a stall: preload accordingly.
  localparam logic [3:0] WAIT_INIT = (MEM_WAIT_CYCLES > 1) ? 4'(MEM_WAIT_CYCLES - 2) : 4'd0;

  mem_state_e       state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             mem_req;
  logic             mem_stall;
  logic             hazard_stall;

  hazard_detect u_hazard_detect (
    .forwardEnable         (forwardEnable),
    .src1_id               (src1_id),
    .src2_id               (src2_id),
    .src1Used_id           (src1Used_id),
    .twoSrc_id             (twoSrc_id),
    .destination_exe       (destination_exe),
    .writebackEnabled_exe  (writebackEnabled_exe),
    .memoryReadEnabled_exe (memoryReadEnabled_exe),
    .destination_mem       (destination_mem),
    .writebackEnabled_mem  (writebackEnabled_mem),
    .hazard_id             (hazard_id)
  );

  assign mem_req = memoryReadEnabled_mem || memoryWriteEnabled_mem;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_stall  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          mem_stall = 1'b1;
          if (MEM_WAIT_CYCLES == 1) begin
            state_d = MEM_DONE;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      MEM_WAIT: begin
        mem_stall = 1'b1;
        if (wait_cnt_q == 4'd0) state_d = MEM_DONE;
        else wait_cnt_d = wait_cnt_q - 4'd1;
      end
      MEM_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // A stalled memory access masks everything; a taken branch squashes the ID instruction.
  always_comb begin
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    freeze_exe   = 1'b0;
    freeze_mem   = 1'b0;
    freeze_wb    = 1'b0;
    flush_id     = 1'b0;
    flush_exe    = 1'b0;
    hazard_stall = 1'b0;
    if (mem_stall) begin
      freeze_if  = 1'b1;
      freeze_id  = 1'b1;
      freeze_exe = 1'b1;
      freeze_mem = 1'b1;
      freeze_wb  = 1'b1;
    end else if (branchTaken_exe) begin
      flush_id  = 1'b1;
      flush_exe = 1'b1;
    end else if (hazard_id) begin
      hazard_stall = 1'b1;
      freeze_if    = 1'b1;
      freeze_id    = 1'b1;
      flush_exe    = 1'b1;
    end
  end

  always_comb begin
    hz_cnt_d  = hz_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (hazard_stall && (hz_cnt_q != '1)) hz_cnt_d = hz_cnt_q + CNT_W'(1);
    if (mem_stall && (mem_cnt_q != '1))   mem_cnt_d = mem_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      hz_cnt_q   <= '0;
      mem_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hz_cnt_q   <= hz_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
    end
  end

  assign memBusy          = (state_q != IDLE);
  assign hazardStallCount = hz_cnt_q;
  assign memStallCount    = mem_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, two instances
// (4 wait cycles / 16-bit counters, and 1 wait cycle / 3-bit counters for saturation).
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       forwardEnable;
  logic [3:0] src1_id, src2_id;
  logic       src1Used_id, twoSrc_id;
  logic [3:0] destination_exe;
  logic       writebackEnabled_exe, memoryReadEnabled_exe;
  logic [3:0] destination_mem;
  logic       writebackEnabled_mem;
  logic       memoryReadEnabled_mem, memoryWriteEnabled_mem;
  logic       branchTaken_exe;

  logic hazard_id_a, freeze_if_a, freeze_id_a, freeze_exe_a, freeze_mem_a, freeze_wb_a;
  logic flush_id_a, flush_exe_a, memBusy_a;
  logic [15:0] hazardStallCount_a, memStallCount_a;
  logic hazard_id_b, freeze_if_b, freeze_id_b, freeze_exe_b, freeze_mem_b, freeze_wb_b;
  logic flush_id_b, flush_exe_b, memBusy_b;
  logic [2:0] hazardStallCount_b, memStallCount_b;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state per instance: cycles elapsed in the current access (0 = none) and counts.
  int mwc[2]  = '{4, 1};
  int cmax[2] = '{65535, 7};
  int acc_k[2];
  int hz_c[2];
  int mem_c[2];

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_WAIT_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .forwardEnable(forwardEnable),
    .src1_id(src1_id), .src2_id(src2_id), .src1Used_id(src1Used_id), .twoSrc_id(twoSrc_id),
    .destination_exe(destination_exe), .writebackEnabled_exe(writebackEnabled_exe),
    .memoryReadEnabled_exe(memoryReadEnabled_exe), .destination_mem(destination_mem),
    .writebackEnabled_mem(writebackEnabled_mem), .memoryReadEnabled_mem(memoryReadEnabled_mem),
    .memoryWriteEnabled_mem(memoryWriteEnabled_mem), .branchTaken_exe(branchTaken_exe),
    .hazard_id(hazard_id_a), .freeze_if(freeze_if_a), .freeze_id(freeze_id_a),
    .freeze_exe(freeze_exe_a), .freeze_mem(freeze_mem_a), .freeze_wb(freeze_wb_a),
    .flush_id(flush_id_a), .flush_exe(flush_exe_a), .memBusy(memBusy_a),
    .hazardStallCount(hazardStallCount_a), .memStallCount(memStallCount_a)
  );

  pipeline_ctrl #(.MEM_WAIT_CYCLES(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .forwardEnable(forwardEnable),
    .src1_id(src1_id), .src2_id(src2_id), .src1Used_id(src1Used_id), .twoSrc_id(twoSrc_id),
    .destination_exe(destination_exe), .writebackEnabled_exe(writebackEnabled_exe),
    .memoryReadEnabled_exe(memoryReadEnabled_exe), .destination_mem(destination_mem),
    .writebackEnabled_mem(writebackEnabled_mem), .memoryReadEnabled_mem(memoryReadEnabled_mem),
    .memoryWriteEnabled_mem(memoryWriteEnabled_mem), .branchTaken_exe(branchTaken_exe),
    .hazard_id(hazard_id_b), .freeze_if(freeze_if_b), .freeze_id(freeze_id_b),
    .freeze_exe(freeze_exe_b), .freeze_mem(freeze_mem_b), .freeze_wb(freeze_wb_b),
    .flush_id(flush_id_b), .flush_exe(flush_exe_b), .memBusy(memBusy_b),
    .hazardStallCount(hazardStallCount_b), .memStallCount(memStallCount_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hazard();
    logic [3:0] src[2];
    bit         used[2];
    bit         h;
    src[0] = src1_id;  used[0] = src1Used_id;
    src[1] = src2_id;  used[1] = twoSrc_id;
    h = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (used[s]) begin
        if (forwardEnable)
          h = h | ((src[s] == destination_exe) && memoryReadEnabled_exe);
        else
          h = h | ((src[s] == destination_exe) && writebackEnabled_exe)
                | ((src[s] == destination_mem) && writebackEnabled_mem);
      end
    end
    return h;
  endfunction

  task automatic set_idle();
    rst = 1'b0; forwardEnable = 1'b0;
    src1_id = 4'd0; src2_id = 4'd0; src1Used_id = 1'b0; twoSrc_id = 1'b0;
    destination_exe = 4'd0; writebackEnabled_exe = 1'b0; memoryReadEnabled_exe = 1'b0;
    destination_mem = 4'd0; writebackEnabled_mem = 1'b0;
    memoryReadEnabled_mem = 1'b0; memoryWriteEnabled_mem = 1'b0; branchTaken_exe = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_k[i] = 0; hz_c[i] = 0; mem_c[i] = 0;
    end
  endtask

  // Called just after inputs change at a negedge: check this cycle, then advance the model.
  task automatic step();
    bit hz, br, mreq, bub, fl;
    bit stall[2];
    logic [8:0] exp_v[2];
    #1;
    hz   = ref_hazard();
    br   = branchTaken_exe;
    mreq = memoryReadEnabled_mem | memoryWriteEnabled_mem;
    for (int i = 0; i < 2; i++) begin
      stall[i] = (acc_k[i] == 0) ? mreq : (acc_k[i] < mwc[i]);
      fl  = !stall[i] && br;
      bub = !stall[i] && !br && hz;
      exp_v[i] = {hz, stall[i] | bub, stall[i] | bub, stall[i], stall[i], stall[i],
                  fl, fl | bub, acc_k[i] != 0};
    end
    chk("ctl_a", {hazard_id_a, freeze_if_a, freeze_id_a, freeze_exe_a, freeze_mem_a, freeze_wb_a,
                  flush_id_a, flush_exe_a, memBusy_a}, exp_v[0]);
    chk("ctl_b", {hazard_id_b, freeze_if_b, freeze_id_b, freeze_exe_b, freeze_mem_b, freeze_wb_b,
                  flush_id_b, flush_exe_b, memBusy_b}, exp_v[1]);
    chk("hzcnt_a",  hazardStallCount_a, hz_c[0]);
    chk("memcnt_a", memStallCount_a,    mem_c[0]);
    chk("hzcnt_b",  hazardStallCount_b, hz_c[1]);
    chk("memcnt_b", memStallCount_b,    mem_c[1]);
    $display("t=%0t rst=%0b memReq=%0b br=%0b hz=%0b | a: ctl=%03h hzc=%0d memc=%0d | b: ctl=%03h hzc=%0d memc=%0d",
             $time, rst, mreq, br, hz, exp_v[0], hazardStallCount_a, memStallCount_a,
             exp_v[1], hazardStallCount_b, memStallCount_b);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        acc_k[i] = 0; hz_c[i] = 0; mem_c[i] = 0;
      end else begin
        if (!stall[i] && !br && hz && hz_c[i] < cmax[i]) hz_c[i]++;
        if (stall[i] && mem_c[i] < cmax[i]) mem_c[i]++;
        if (acc_k[i] == 0)           acc_k[i] = mreq ? 1 : 0;
        else if (acc_k[i] < mwc[i])  acc_k[i]++;
        else                         acc_k[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle(); rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n_stall;
    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset state
    step();
    chk("rst_busy_a", memBusy_a, 0);
    chk("rst_hz_a", hazardStallCount_a, 0);
    chk("rst_mem_a", memStallCount_a, 0);
    chk("rst_freeze_a", freeze_if_a, 0);

    // Load-use with forwarding: one bubble
    forwardEnable = 1'b1; destination_exe = 4'd3; memoryReadEnabled_exe = 1'b1;
    writebackEnabled_exe = 1'b1; src1_id = 4'd3; src1Used_id = 1'b1;
    #1;
    chk("lu_bubble", {freeze_if_a, freeze_id_a, flush_exe_a, freeze_exe_a}, 4'b1110);
    step();
    set_idle();
    step();
    chk("lu_hzcnt", hazardStallCount_a, 1);

    // No forwarding: MEM writeback vs src2, gated by twoSrc_id
    destination_mem = 4'd5; writebackEnabled_mem = 1'b1; src2_id = 4'd5; twoSrc_id = 1'b1;
    #1; chk("nofwd_hz", hazard_id_a, 1);
    step();
    twoSrc_id = 1'b0;
    #1; chk("nofwd_nosrc2", {hazard_id_a, freeze_if_a}, 2'b00);
    step();

    // Memory stall length
    do_reset();
    memoryReadEnabled_mem = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (freeze_wb_a) n_stall++;
      step();
    end
    memoryReadEnabled_mem = 1'b0;
    chk("mem4_stalls", n_stall, 4);
    chk("mem4_count", memStallCount_a, 4);
    step();

    do_reset();
    memoryWriteEnabled_mem = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 2; i++) begin
      #1; if (freeze_wb_b) n_stall++;
      step();
    end
    memoryWriteEnabled_mem = 1'b0;
    chk("mem1_stalls", n_stall, 1);
    chk("mem1_count", memStallCount_b, 1);
    repeat (4) step();

    // Branch during a memory stall: flush only on the release cycle
    do_reset();
    memoryReadEnabled_mem = 1'b1; branchTaken_exe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; chk("br_in_stall", {flush_id_a, flush_exe_a}, (i == 4) ? 2'b11 : 2'b00);
      step();
    end
    set_idle();
    step();

    // Branch together with a hazard: flush wins, no hazard count
    do_reset();
    forwardEnable = 1'b1; destination_exe = 4'd7; memoryReadEnabled_exe = 1'b1;
    src2_id = 4'd7; twoSrc_id = 1'b1; branchTaken_exe = 1'b1;
    #1; chk("br_hz_out", {flush_id_a, flush_exe_a, freeze_if_a, freeze_id_a}, 4'b1100);
    step();
    set_idle();
    step();
    chk("br_hz_cnt", hazardStallCount_a, 0);

    // Reset in the second MEM_WAIT cycle aborts the access
    do_reset();
    memoryReadEnabled_mem = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    set_idle();
    #1;
    chk("abort_busy", memBusy_a, 0);
    chk("abort_memcnt", memStallCount_a, 0);
    step();

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rst                    = ($urandom_range(0, 49) == 0);
      forwardEnable          = 1'($urandom_range(0, 1));
      src1_id                = 4'($urandom_range(0, 3));
      src2_id                = 4'($urandom_range(0, 3));
      src1Used_id            = 1'($urandom_range(0, 1));
      twoSrc_id              = 1'($urandom_range(0, 1));
      destination_exe        = 4'($urandom_range(0, 3));
      writebackEnabled_exe   = 1'($urandom_range(0, 1));
      memoryReadEnabled_exe  = 1'($urandom_range(0, 1));
      destination_mem        = 4'($urandom_range(0, 3));
      writebackEnabled_mem   = 1'($urandom_range(0, 1));
      memoryReadEnabled_mem  = ($urandom_range(0, 5) == 0);
      memoryWriteEnabled_mem = ($urandom_range(0, 7) == 0);
      branchTaken_exe        = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
